// File: rtl/tile_game_pkg.sv
// Shared types and default sizes for the tile-matching game controller.
package tile_game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PICK1   = 3'd1,
    PICK2   = 3'd2,
    COMPARE = 3'd3,
    SHOW    = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int unsigned NUM_TILES_DEF = 10;
  localparam int unsigned SYM_W_DEF     = 3;
  localparam int unsigned IDX_W         = $clog2(NUM_TILES_DEF);

endpackage

// File: rtl/tile_onehot_decode.sv
// Turns the switch bank into a tile index plus a flag saying exactly one switch is up.
module tile_onehot_decode
  import tile_game_pkg::*;
#(
  parameter int unsigned NUM_TILES = NUM_TILES_DEF,
  parameter int unsigned IW        = $clog2(NUM_TILES)
) (
  input  logic [NUM_TILES-1:0] sw,
  output logic [IW-1:0]        idx,
  output logic                 onehot
);

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < NUM_TILES; i++) begin
      if (sw[i]) idx = IW'(i);
    end
    onehot = (sw != '0) && ((sw & (sw - NUM_TILES'(1))) == '0);
  end

endmodule

// File: rtl/tile_match_controller.sv
// One turn of the tile-matching game: two picks, compare, timed reveal, match bookkeeping.
module tile_match_controller
  import tile_game_pkg::*;
#(
  parameter int unsigned NUM_TILES   = NUM_TILES_DEF,
  parameter int unsigned SYM_W       = SYM_W_DEF,
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       reset,
  input  logic                       ingame_on,
  input  logic                       select1,
  input  logic                       select2,
  input  logic [NUM_TILES-1:0]       sw,
  input  logic [NUM_TILES*SYM_W-1:0] layout,
  output logic [NUM_TILES-1:0]       reveal,
  output logic [NUM_TILES-1:0]       matched,
  output logic [SYM_W-1:0]           sym_a,
  output logic [SYM_W-1:0]           sym_b,
  output logic [7:0]                 move_count,
  output logic                       bad_pick,
  output logic                       game_over,
  output logic [2:0]                 state
);

  localparam int unsigned IW = $clog2(NUM_TILES);
  localparam int unsigned CW = $clog2(SHOW_CYCLES) + 1;

  state_t                     state_q, state_d;
  logic                       sel1_q, sel2_q;
  logic [NUM_TILES*SYM_W-1:0] layout_q, layout_d;
  logic [NUM_TILES-1:0]       matched_d;
  logic [IW-1:0]              idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic                       pick_a_q, pick_a_d, pick_b_q, pick_b_d;
  logic [7:0]                 move_d;
  logic                       bad_d;
  logic [CW-1:0]              cnt_q, cnt_d;

  logic          rise1, rise2;
  logic [IW-1:0] sw_idx;
  logic          sw_onehot;

  assign rise1 = select1 & ~sel1_q;
  assign rise2 = select2 & ~sel2_q;

  tile_onehot_decode #(
    .NUM_TILES(NUM_TILES),
    .IW       (IW)
  ) u_decode (
    .sw    (sw),
    .idx   (sw_idx),
    .onehot(sw_onehot)
  );

  assign sym_a     = pick_a_q ? layout_q[idx_a_q*SYM_W +: SYM_W] : '0;
  assign sym_b     = pick_b_q ? layout_q[idx_b_q*SYM_W +: SYM_W] : '0;
  assign game_over = (state_q == DONE);
  assign state     = state_q;

  always_comb begin
    reveal = matched;
    if (pick_a_q) reveal[idx_a_q] = 1'b1;
    if (pick_b_q) reveal[idx_b_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    layout_d  = layout_q;
    matched_d = matched;
    idx_a_d   = idx_a_q;
    idx_b_d   = idx_b_q;
    pick_a_d  = pick_a_q;
    pick_b_d  = pick_b_q;
    move_d    = move_count;
    bad_d     = 1'b0;
    cnt_d     = cnt_q;

    // Quitting outranks every state action; matched/move_count survive for the HEX display.
    if (state_q != IDLE && !ingame_on) begin
      state_d  = IDLE;
      pick_a_d = 1'b0;
      pick_b_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ingame_on) begin
            layout_d  = layout;
            matched_d = '0;
            pick_a_d  = 1'b0;
            pick_b_d  = 1'b0;
            move_d    = '0;
            state_d   = PICK1;
          end
        end
        PICK1: begin
          if (rise1) begin
            if (sw_onehot && !matched[sw_idx]) begin
              idx_a_d  = sw_idx;
              pick_a_d = 1'b1;
              state_d  = PICK2;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        PICK2: begin
          if (rise2) begin
            if (sw_onehot && !matched[sw_idx] && (sw_idx != idx_a_q)) begin
              idx_b_d  = sw_idx;
              pick_b_d = 1'b1;
              state_d  = COMPARE;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        COMPARE: begin
          if (move_count != 8'hFF) move_d = move_count + 8'd1;
          if (sym_a == sym_b) begin
            matched_d[idx_a_q] = 1'b1;
            matched_d[idx_b_q] = 1'b1;
          end
          cnt_d   = CW'(SHOW_CYCLES - 1);
          state_d = SHOW;
        end
        SHOW: begin
          if (cnt_q == '0) begin
            pick_a_d = 1'b0;
            pick_b_d = 1'b0;
            state_d  = (matched == '1) ? DONE : PICK1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel1_q     <= 1'b0;
      sel2_q     <= 1'b0;
      layout_q   <= '0;
      matched    <= '0;
      idx_a_q    <= '0;
      idx_b_q    <= '0;
      pick_a_q   <= 1'b0;
      pick_b_q   <= 1'b0;
      move_count <= '0;
      bad_pick   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      sel1_q     <= select1;
      sel2_q     <= select2;
      layout_q   <= layout_d;
      matched    <= matched_d;
      idx_a_q    <= idx_a_d;
      idx_b_q    <= idx_b_d;
      pick_a_q   <= pick_a_d;
      pick_b_q   <= pick_b_d;
      move_count <= move_d;
      bad_pick   <= bad_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_tile_match_controller.sv
// Scoreboard bench for tile_match_controller: stimulus queues expected events, a monitor checks them.
module tb_tile_match_controller;
  import tile_game_pkg::*;

  localparam int unsigned NT = 10;
  localparam int unsigned SW = 3;
  localparam int unsigned SC = 4;

  logic             CLOCK_50 = 1'b0;
  logic             reset, ingame_on, select1, select2;
  logic [NT-1:0]    sw;
  logic [NT*SW-1:0] layout;
  logic [NT-1:0]    reveal, matched;
  logic [SW-1:0]    sym_a, sym_b;
  logic [7:0]       move_count;
  logic             bad_pick, game_over;
  logic [2:0]       state;

  always #5 CLOCK_50 = ~CLOCK_50;

  tile_match_controller #(
    .NUM_TILES  (NT),
    .SYM_W      (SW),
    .SHOW_CYCLES(SC)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .ingame_on (ingame_on),
    .select1   (select1),
    .select2   (select2),
    .sw        (sw),
    .layout    (layout),
    .reveal    (reveal),
    .matched   (matched),
    .sym_a     (sym_a),
    .sym_b     (sym_b),
    .move_count(move_count),
    .bad_pick  (bad_pick),
    .game_over (game_over),
    .state     (state)
  );

  typedef enum int {EV_BAD, EV_SHOW, EV_END} ev_t;
  typedef struct {
    ev_t        kind;
    logic [2:0] st;
    logic [9:0] rev;
    logic [9:0] mat;
    logic [7:0] mc;
    logic [2:0] sa;
    logic [2:0] sb;
    int         slen;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [9:0] m_matched;
  int         m_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] sym(input int t);
    return 3'(t / 2);
  endfunction

  function automatic logic [9:0] oh(input int t);
    logic [9:0] one;
    one = 10'd1;
    return one << t;
  endfunction

  task automatic push(input ev_t k, input logic [2:0] st, input logic [9:0] rev, input logic [9:0] mat,
                      input logic [7:0] mc, input logic [2:0] sa, input logic [2:0] sb, input int slen);
    exp_t e;
    e.kind = k; e.st = st; e.rev = rev; e.mat = mat; e.mc = mc; e.sa = sa; e.sb = sb; e.slen = slen;
    q.push_back(e);
  endtask

  // Monitor: an output event is a bad_pick pulse, entry into SHOW, or exit from SHOW.
  logic [2:0] prev_st;
  int         show_len;

  task automatic take(input ev_t k, input string pfx);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_unexpected: got event %0d expected none", pfx, k);
      return;
    end
    e = q.pop_front();
    check({pfx, "_kind"}, 32'(k), 32'(e.kind));
    check({pfx, "_state"}, 32'(state), 32'(e.st));
    check({pfx, "_reveal"}, 32'(reveal), 32'(e.rev));
    check({pfx, "_matched"}, 32'(matched), 32'(e.mat));
    check({pfx, "_move_count"}, 32'(move_count), 32'(e.mc));
    check({pfx, "_sym_a"}, 32'(sym_a), 32'(e.sa));
    check({pfx, "_sym_b"}, 32'(sym_b), 32'(e.sb));
    if (k == EV_END) check({pfx, "_show_len"}, 32'(show_len), 32'(e.slen));
  endtask

  initial begin
    prev_st  = 3'(IDLE);
    show_len = 0;
    forever begin
      @(negedge CLOCK_50);
      if (reset) begin
        prev_st  = 3'(IDLE);
        show_len = 0;
      end else begin
        if (bad_pick) take(EV_BAD, "bad");
        if (state == SHOW && prev_st != SHOW) begin
          show_len = 0;
          take(EV_SHOW, "show");
        end
        if (state == SHOW) show_len++;
        if (prev_st == SHOW && state != SHOW) take(EV_END, "end");
        prev_st = state;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic press1(input logic [9:0] s, input int hold);
    sw = s; select1 = 1'b1; tick(hold); select1 = 1'b0; tick(1);
  endtask

  task automatic press2(input logic [9:0] s, input int hold);
    sw = s; select2 = 1'b1; tick(hold); select2 = 1'b0; tick(1);
  endtask

  task automatic start_game();
    ingame_on = 1'b1;
    tick(1);
    m_matched = '0;
    m_mc      = 0;
  endtask

  // Pushes the SHOW-entry event and updates the model; the caller drives the second pick.
  task automatic expect_show(input int a, input int b);
    if (sym(a) == sym(b)) m_matched = m_matched | oh(a) | oh(b);
    if (m_mc < 255) m_mc++;
    push(EV_SHOW, SHOW, m_matched | oh(a) | oh(b), m_matched, 8'(m_mc), sym(a), sym(b), 0);
  endtask

  task automatic finish_turn(input int a, input int b);
    logic [2:0] nxt;
    expect_show(a, b);
    nxt = (m_matched == 10'h3FF) ? 3'(DONE) : 3'(PICK1);
    push(EV_END, nxt, m_matched, m_matched, 8'(m_mc), 3'd0, 3'd0, SC);
    press2(oh(b), 1);
    tick(SC);
    check("turn_state", 32'(state), 32'(nxt));
  endtask

  task automatic do_turn(input int a, input int b);
    press1(oh(a), 1);
    finish_turn(a, b);
  endtask

  initial begin
    reset = 1'b0; ingame_on = 1'b0; select1 = 1'b0; select2 = 1'b0; sw = '0;
    for (int i = 0; i < int'(NT); i++) layout[i*SW +: SW] = sym(i);
    #2 reset = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'(IDLE));
    check("rst_outputs", {reveal, matched, sym_a, sym_b}, 32'd0);
    check("rst_move_count", 32'(move_count), 32'd0);
    check("rst_flags", {bad_pick, game_over}, 2'b00);
    tick(1);
    reset = 1'b0;
    tick(1);

    start_game();
    check("start_state", 32'(state), 32'(PICK1));

    press2(oh(0), 1);
    check("pick1_ignores_sel2", 32'(state), 32'(PICK1));

    push(EV_BAD, PICK1, m_matched, m_matched, 8'(m_mc), 3'd0, 3'd0, 0);
    press1(10'h003, 10);
    check("reject_twohot_state", 32'(state), 32'(PICK1));

    do_turn(0, 2);
    check("mismatch_matched", 32'(matched), 32'd0);
    check("mismatch_move_count", 32'(move_count), 32'd1);

    do_turn(0, 1);
    check("match_matched", 32'(matched), 32'h003);
    check("match_move_count", 32'(move_count), 32'd2);

    push(EV_BAD, PICK1, m_matched, m_matched, 8'(m_mc), 3'd0, 3'd0, 0);
    press1(oh(0), 1);
    check("reject_matched_state", 32'(state), 32'(PICK1));

    press1(oh(2), 1);
    push(EV_BAD, PICK2, m_matched | oh(2), m_matched, 8'(m_mc), sym(2), 3'd0, 0);
    press2(oh(2), 1);
    check("reject_same_state", 32'(state), 32'(PICK2));
    press1(oh(3), 1);
    check("pick2_ignores_sel1", 32'(state), 32'(PICK2));
    finish_turn(2, 3);

    // Quit while the picks are on display.
    press1(oh(4), 1);
    expect_show(4, 6);
    push(EV_END, IDLE, m_matched, m_matched, 8'(m_mc), 3'd0, 3'd0, 1);
    press2(oh(6), 1);
    ingame_on = 1'b0;
    tick(1);
    check("quit_state", 32'(state), 32'(IDLE));
    check("quit_reveal", 32'(reveal), 32'h00F);
    check("quit_syms", {sym_a, sym_b}, 6'd0);
    check("quit_move_count", 32'(move_count), 32'd4);

    start_game();
    check("restart_matched", 32'(matched), 32'd0);
    check("restart_move_count", 32'(move_count), 32'd0);
    for (int p = 0; p < 5; p++) do_turn(2*p, 2*p + 1);
    check("full_game_over", 32'(game_over), 32'd1);
    check("full_matched", 32'(matched), 32'h3FF);
    check("full_move_count", 32'(move_count), 32'd5);
    ingame_on = 1'b0;
    tick(1);
    check("done_quit_state", 32'(state), 32'(IDLE));
    check("done_quit_matched", 32'(matched), 32'h3FF);

    // Layout changes after start must not affect the compare.
    start_game();
    layout = '0;
    for (int t = 0; t < 260; t++) do_turn(0, 2);
    check("sat_move_count", 32'(move_count), 32'd255);
    for (int i = 0; i < int'(NT); i++) layout[i*SW +: SW] = sym(i);

    press1(oh(4), 1);
    press2(oh(5), 1);
    check("pre_reset_state", 32'(state), 32'(SHOW));
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", 32'(state), 32'(IDLE));
    check("async_rst_outputs", {reveal, matched, sym_a, sym_b}, 32'd0);
    check("async_rst_move_count", 32'(move_count), 32'd0);
    check("async_rst_flags", {bad_pick, game_over}, 2'b00);
    ingame_on = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(2);

    check("sb_drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
